store_bypass_buffer: RTL
========================

Name: store_bypass_buffer

Overview:
- Parametrised successor to the per-byte bypass mux used on L1 data cache loads.
- Holds up to DEPTH pending stores, each with a byte mask, in FIFO order, and drains them to the cache/memory side through a valid/ready handshake.
- Merges a load's cache data with all matching pending stores, byte by byte, with the newest store winning. The merged result is registered.
- Coalesces back-to-back stores to the same line into the youngest entry.

Parameters:
- DATA_BYTES, 16, bytes per entry/line; data width is 8*DATA_BYTES.
- ADDR_WIDTH, 26, line address width.
- DEPTH, 4, number of entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enq_valid_i  in  1  store request present.
- enq_ready_o  out  1  buffer can accept a store; equals !full_o.
- enq_addr_i  in  ADDR_WIDTH  store line address.
- enq_data_i  in  8*DATA_BYTES  store data.
- enq_mask_i  in  DATA_BYTES  byte enables; bit i covers data byte i (bits 8i+7:8i).
- lookup_valid_i  in  1  load lookup request.
- lookup_addr_i  in  ADDR_WIDTH  load line address.
- lookup_data_i  in  8*DATA_BYTES  cache data for the load.
- result_valid_o  out  1  registered lookup_valid_i.
- result_data_o  out  8*DATA_BYTES  merged load data.
- result_mask_o  out  DATA_BYTES  bytes supplied by the buffer.
- result_hit_o  out  1  OR of result_mask_o.
- drain_valid_o  out  1  head entry is valid.
- drain_ready_i  in  1  downstream accepts the head entry.
- drain_addr_o  out  ADDR_WIDTH  head entry address.
- drain_data_o  out  8*DATA_BYTES  head entry data.
- drain_mask_o  out  DATA_BYTES  head entry mask.
- count_o  out  clog2(DEPTH)+1  number of occupied entries.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage: circular buffer with head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register. Entry fields are addr, data and mask.
- Reset (reset_n low at a clock edge):
  - count and both pointers become 0.
  - All entry masks clear.
  - result_valid_o, result_data_o, result_mask_o and result_hit_o become 0.
  - drain_valid_o is 0, empty_o is 1, full_o is 0.
  - Reset asserted mid-operation discards all pending stores, and any lookup presented in that cycle produces no result.
- Enqueue accept: enq_valid_i && enq_ready_o. enq_ready_o depends only on registered state, never on enq_* or drain_ready_i.
- Coalesce: when an accepted store hits the youngest entry, it merges into that entry instead of allocating. All of these must hold:
  - count > 0;
  - enq_addr_i equals the address of the youngest entry (tail-1);
  - that entry is not being drained this cycle, i.e. not (count == 1 and drain handshake).
- Merge rule: for each i with enq_mask_i[i] set, data byte i is replaced and mask bit i is set. count does not change.
- Allocate: any other accepted store writes at tail, tail increments and wraps, and count increments.
- Drain: drain_valid_o = !empty_o. A handshake is drain_valid_o && drain_ready_i. On a handshake head increments, count decrements, and the entry mask clears. drain_* outputs come directly from the head entry (zero latency). drain_* must hold stable while drain_valid_o is high and drain_ready_i is low.
- Simultaneous allocate and drain: count is unchanged and both pointers advance. When full, enqueue is still refused in that cycle; no bypass from drain to ready.
- Lookup: latency is 1 cycle. Evaluated combinationally against the entry contents before any same-cycle update, then registered.
  - A store enqueued in the same cycle is not visible to that lookup.
  - An entry drained in the same cycle is still visible to that lookup.
  - Per byte i: take the youngest valid entry, in order head to tail-1, whose addr equals lookup_addr_i and whose mask[i] is set. That entry's byte i wins and result_mask_o[i] = 1. If no entry matches, lookup_data_i byte i is used and result_mask_o[i] = 0.
  - When lookup_valid_i is low, result_valid_o becomes 0 and the result data, mask and hit registers hold their previous values.
- Wrap-around: the age order is defined relative to head. Physical index order is never used for priority.

Test Plan:
- Reset, then enqueue addr 0x10, mask 0x000F, data bytes 0-3 = 0xAA; lookup 0x10 with cache data all 0x55 -> next cycle result bytes 0-3 = 0xAA, others 0x55, result_mask_o = 0x000F, hit = 1, count_o = 1.
- Enqueue 0x10/mask 0x00FF/0x11, then 0x20/mask 0xFFFF/0x22, then 0x10/mask 0x000F/0x33 -> count_o = 3 (no coalesce, because 0x20 is youngest); lookup 0x10 -> bytes 0-3 = 0x33, bytes 4-7 = 0x11, mask 0x00FF.
- Two consecutive stores to 0x30 with masks 0x0003 and 0x0300 -> count_o = 1; drain shows mask 0x0303 with both bytes' data.
- Fill to DEPTH=4 with drain_ready_i = 0 -> full_o = 1, enq_ready_o = 0, and a fifth store is refused. Then hold drain_ready_i = 1 and keep enqueueing every cycle for 12 cycles -> pointers wrap, drain order equals enqueue order, and count_o stays between 3 and 4.
- In one cycle, enqueue 0x40 and look up 0x40 -> result_hit_o = 0. In the cycle the head 0x50 drains, look up 0x50 -> result_hit_o = 1.
- With 3 entries pending, assert reset_n = 0 for 1 cycle -> count_o = 0, empty_o = 1, drain_valid_o = 0, result_valid_o = 0; a subsequent lookup to a formerly pending address returns cache data with mask 0.

Source files
------------

// File: rtl/store_bypass_buffer.sv
// ----------------------------------------------------------------------------
// store_bypass_buffer: FIFO of pending masked stores with byte-wise load merge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_bypass_buffer #(
  parameter int DATA_BYTES = 16,
  parameter int ADDR_WIDTH = 26,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enq_valid_i,
  output logic                      enq_ready_o,
  input  logic [ADDR_WIDTH-1:0]     enq_addr_i,
  input  logic [8*DATA_BYTES-1:0]   enq_data_i,
  input  logic [DATA_BYTES-1:0]     enq_mask_i,
  input  logic                      lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0]     lookup_addr_i,
  input  logic [8*DATA_BYTES-1:0]   lookup_data_i,
  output logic                      result_valid_o,
  output logic [8*DATA_BYTES-1:0]   result_data_o,
  output logic [DATA_BYTES-1:0]     result_mask_o,
  output logic                      result_hit_o,
  output logic                      drain_valid_o,
  input  logic                      drain_ready_i,
  output logic [ADDR_WIDTH-1:0]     drain_addr_o,
  output logic [8*DATA_BYTES-1:0]   drain_data_o,
  output logic [DATA_BYTES-1:0]     drain_mask_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DW-1:0]         data_q [DEPTH];
  logic [DW-1:0]         data_d [DEPTH];
  logic [DATA_BYTES-1:0] mask_q [DEPTH];
  logic [DATA_BYTES-1:0] mask_d [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, young, idx;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  res_valid_q;
  logic [DW-1:0]         res_data_q, res_data_d;
  logic [DATA_BYTES-1:0] res_mask_q, res_mask_d;
  logic                  res_hit_q;

  logic                  enq_acc, drain_hs, coalesce, alloc;

  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign enq_ready_o    = !full_o;
  assign drain_valid_o  = !empty_o;
  assign drain_addr_o   = addr_q[head_q];
  assign drain_data_o   = data_q[head_q];
  assign drain_mask_o   = mask_q[head_q];
  assign count_o        = count_q;
  assign result_valid_o = res_valid_q;
  assign result_data_o  = res_data_q;
  assign result_mask_o  = res_mask_q;
  assign result_hit_o   = res_hit_q;

  assign enq_acc  = enq_valid_i && enq_ready_o;
  assign drain_hs = drain_valid_o && drain_ready_i;
  assign young    = tail_q - PTR_W'(1);
  // Merging into an entry that leaves this cycle would lose the store.
  assign coalesce = enq_acc && !empty_o && (addr_q[young] == enq_addr_i)
                    && !((count_q == CNT_W'(1)) && drain_hs);
  assign alloc    = enq_acc && !coalesce;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain_hs) begin
      mask_d[head_q] = '0;
      head_d         = head_q + PTR_W'(1);
    end
    if (coalesce) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (enq_mask_i[b]) data_d[young][8*b +: 8] = enq_data_i[8*b +: 8];
      end
      mask_d[young] = mask_q[young] | enq_mask_i;
    end
    if (alloc) begin
      addr_d[tail_q] = enq_addr_i;
      data_d[tail_q] = enq_data_i;
      mask_d[tail_q] = enq_mask_i;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (alloc && !drain_hs)      count_d = count_q + CNT_W'(1);
    else if (!alloc && drain_hs) count_d = count_q - CNT_W'(1);
  end

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    res_data_d = lookup_data_i;
    res_mask_d = '0;
    idx        = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
        for (int b = 0; b < DATA_BYTES; b++) begin
          if (mask_q[idx][b]) begin
            res_data_d[8*b +: 8] = data_q[idx][8*b +: 8];
            res_mask_d[b]        = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_mask_q  <= '0;
      res_hit_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      res_valid_q <= lookup_valid_i;
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= mask_d[i];
      if (lookup_valid_i) begin
        res_data_q <= res_data_d;
        res_mask_q <= res_mask_d;
        res_hit_q  <= |res_mask_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
    end
  end

endmodule

`default_nettype wire
